// File: rtl/output_sram_writer_pkg.sv
// Shared definitions for the output SRAM writer and its neighbours
// (SRAM_1R/SRAM_1W wrappers, Bellman-Ford core).
package output_sram_writer_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISH
  } writerState;

endpackage

// File: rtl/output_sram_writer_if.sv
// Job control, word stream and registered SRAM write port of the output writer.
interface output_sram_writer_if
  import output_sram_writer_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              start;
  logic [ADDR_W-1:0] BaseAddress;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              write_hold;
  logic [ADDR_W-1:0] WriteAddress;
  logic [DATA_W-1:0] WriteBus;
  logic              WriteEnable;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  modport master (
    output start, BaseAddress, in_valid, in_data, in_last, write_hold,
    input  in_ready, WriteAddress, WriteBus, WriteEnable, busy, done, overflow, word_count
  );

  modport slave (
    input  start, BaseAddress, in_valid, in_data, in_last, write_hold,
    output in_ready, WriteAddress, WriteBus, WriteEnable, busy, done, overflow, word_count
  );

endinterface

// File: rtl/output_sram_writer_sync_fifo.sv
// Single-clock staging FIFO; a push is taken while full if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       popData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      if (doPush && !doPop)      count <= count + (PTR_W + 1)'(1);
      else if (doPop && !doPush) count <= count - (PTR_W + 1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count decide which entries are valid.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/output_sram_writer.sv
// Streams accepted words through a staging FIFO into consecutive SRAM addresses
// starting at BaseAddress, yielding to write_hold and stopping at the top of the address space.
module output_sram_writer
  import output_sram_writer_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clock,
  input logic                 reset,
  output_sram_writer_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  writerState        state;
  writerState        nextState;
  logic [ADDR_W-1:0] addrCounter;
  logic [ADDR_W-1:0] wrAddress;
  logic [DATA_W-1:0] wrData;
  logic [DATA_W-1:0] fifoHead;
  logic [ADDR_W:0]   wordCount;
  logic [CNT_W-1:0]  fifoCount;
  logic              wrEnable;
  logic              addrExhausted;
  logic              overflowFlag;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              inReady;
  logic              busyOut;
  logic              doneOut;
  logic              accept;
  logic              writeAttempt;
  logic              issueWrite;
  logic              flushFifo;
  logic              startJob;

  assign accept = bus.in_valid && inReady;

  sync_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) stage (
    .clock   (clock),
    .reset   (reset),
    .flush   (flushFifo),
    .push    (accept),
    .pushData(bus.in_data),
    .pop     (issueWrite),
    .popData (fifoHead),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    nextState    = state;
    inReady      = 1'b0;
    busyOut      = 1'b1;
    doneOut      = 1'b0;
    writeAttempt = 1'b0;
    issueWrite   = 1'b0;
    flushFifo    = 1'b0;
    startJob     = 1'b0;
    unique case (state)
      IDLE: begin
        busyOut = 1'b0;
        if (bus.start) begin
          startJob  = 1'b1;
          nextState = RUN;
        end
      end
      RUN: begin
        inReady      = !fifoFull;
        writeAttempt = !fifoEmpty && !bus.write_hold && !overflowFlag;
        if (bus.in_valid && !fifoFull && bus.in_last) nextState = DRAIN;
      end
      DRAIN: begin
        writeAttempt = !fifoEmpty && !bus.write_hold && !overflowFlag;
        if (fifoCount == '0) nextState = FINISH;
      end
      FINISH: begin
        doneOut   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
    // Once the top address has been written, any further write aborts the job.
    if (writeAttempt && addrExhausted) begin
      flushFifo = 1'b1;
      nextState = FINISH;
    end else begin
      issueWrite = writeAttempt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addrCounter   <= '0;
      addrExhausted <= 1'b0;
      overflowFlag  <= 1'b0;
      wordCount     <= '0;
      wrEnable      <= 1'b0;
      wrAddress     <= '0;
      wrData        <= '0;
    end else begin
      wrEnable <= issueWrite;
      if (startJob) begin
        addrCounter   <= bus.BaseAddress;
        addrExhausted <= 1'b0;
        overflowFlag  <= 1'b0;
        wordCount     <= '0;
      end
      if (issueWrite) begin
        wrAddress   <= addrCounter;
        wrData      <= fifoHead;
        addrCounter <= addrCounter + ADDR_W'(1);
        wordCount   <= wordCount + (ADDR_W + 1)'(1);
        if (&addrCounter) addrExhausted <= 1'b1;
      end
      if (flushFifo) overflowFlag <= 1'b1;
    end
  end

  assign bus.in_ready     = inReady;
  assign bus.busy         = busyOut;
  assign bus.done         = doneOut;
  assign bus.overflow     = overflowFlag;
  assign bus.word_count   = wordCount;
  assign bus.WriteEnable  = wrEnable;
  assign bus.WriteAddress = wrAddress;
  assign bus.WriteBus     = wrData;

endmodule
